bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Single-slave bus arbiter sharing the core's memory port between the JTAG debug master, the EX load/store unit and the IF fetch unit. Holds one outstanding transaction at a time and routes the read data back to the granted master. Raises per-unit hold requests that feed the pipeline controller's stall inputs. Drops fetch responses made stale by a pipeline flush, and aborts hung slave accesses with an error after a timeout.

## Interface
- TIMEOUT_CYCLES, default 255: maximum BUSY cycles before abort; legal range 2..255; counter is 8 bits.
- clk  in  1  core clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req_i  in  1  request from master N (N = 0 JTAG, 1 EX, 2 IF); held high until mN_ack_o.
- mN_addr_i  in  32  address; stable while req is high.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_wdata_i  in  32  write data.
- mN_rdata_o  out  32  read data; valid only when mN_ack_o = 1, otherwise 0.
- mN_ack_o  out  1  one-cycle completion pulse.
- mN_err_o  out  1  one-cycle timeout flag; asserted only together with mN_ack_o.
- s_req_o  out  1  slave request; held until s_ack_i or timeout.
- s_addr_o, s_wdata_o  out  32  registered copies of the granted master's address and write data.
- s_we_o  out  1  registered copy of the granted master's write enable.
- s_rdata_i  in  32  slave read data; valid with s_ack_i.
- s_ack_i  in  1  slave completion.
- flush_i  in  1  pipeline flush; same signal as the pipeline controller's flush output.
- hold_ex_o  out  1  = m1_req_i & ~m1_ack_o; routes to the EX stall input.
- hold_if_o  out  1  = m2_req_i & ~m2_ack_o; routes to the ID/IF stall input.

## Operation
- States: IDLE and BUSY. Registers: grant index (2 bits), discard, last_ex, timeout counter, and latched address, wdata and we.
- IDLE: arbitrate among masters whose req is high. A master whose ack is high in the same cycle is excluded.
  - Priority: m0 first, then m1/m2.
  - Between m1 and m2: if last_ex = 1 and m2 is requesting, grant m2. Otherwise m1 wins over m2.
  - last_ex is set on an m1 grant and cleared on an m2 grant. m2 therefore cannot starve behind back-to-back EX accesses.
  - On any grant: latch the request fields, clear the counter and discard, and go to BUSY.
- BUSY: s_req_o = 1 with the latched fields. The counter increments on each cycle without s_ack_i.
  - s_ack_i = 1: capture s_rdata_i and go to IDLE. The next cycle pulses ack to the granted master with rdata = captured data (0 for writes).
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: go to IDLE. The next cycle pulses ack and err to the granted master with rdata = 0.
  - s_ack_i in the same cycle as the timeout: the ack wins and err stays 0.
- Flush: flush_i = 1 while BUSY with grant = m2 sets discard.
  - The slave access still completes.
  - With discard set, the m2 ack/err pulse is suppressed. m2 may already have dropped or changed its request.
  - flush_i has no effect on m0/m1 grants, or when in IDLE.
- s_ack_i while in IDLE is ignored. This covers a late ack after a timeout or reset.
- Reset: state IDLE, s_req_o 0, s_addr_o/s_wdata_o/s_we_o 0, all acks/errs/rdata 0, counter/discard/last_ex 0. An in-flight transaction is abandoned.

## Timing
- Zero-wait slave (ack in the first s_req_o cycle): request in cycle 0, grant in cycle 0, s_req_o in cycle 1, mN_ack_o in cycle 2.
- The slave acks in cycle k ≥ 1 after the grant; the master ack comes in cycle k+1.
- The ack cycle is an IDLE cycle and may grant another master. Sustained throughput is one transaction per 2 cycles.
- Timeout: s_req_o stays high for exactly TIMEOUT_CYCLES cycles. The err pulse comes the cycle after s_req_o drops.
- hold_ex_o/hold_if_o are combinational: high from the first req cycle through the cycle before ack, low in the ack cycle.

## Test plan
- m1 reads 0x1000, slave acks on the first cycle with 0xDEADBEEF → s_req_o high in cycle 1 only; m1_ack_o and m1_rdata_o = 0xDEADBEEF in cycle 2; hold_ex_o high in cycles 0–1.
- m0, m1 and m2 request simultaneously with zero-wait slave → grant order m0, m1, m2; acks in cycles 2, 4, 6.
- m1 and m2 both request continuously → grants alternate m1, m2, m1, m2; m2 is never skipped twice.
- m2 fetch outstanding, flush_i pulsed in BUSY, slave acks 3 cycles later → no m2_ack_o; next m2 request is granted normally.
- TIMEOUT_CYCLES = 4, slave never acks → s_req_o high for 4 cycles; then m1_ack_o = m1_err_o = 1 and rdata = 0. A late s_ack_i is ignored.
- rst asserted mid-BUSY → next cycle s_req_o = 0 and state is IDLE. A subsequent s_ack_i produces no master ack.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - three-master single-slave memory port arbiter
// One outstanding access; stale fetch responses are dropped and hung slave accesses time out.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m2_req_i,
  input  logic [31:0] m2_addr_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_wdata_i,
  output logic [31:0] m2_rdata_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_we_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  input  logic        flush_i,
  output logic        hold_ex_o,
  output logic        hold_if_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_discard;
  logic        r_last_ex;
  logic [7:0]  r_cnt;
  logic [2:0]  r_ack;
  logic [2:0]  r_err;
  logic [31:0] r_rdata;

  logic [2:0]  w_req;
  logic        w_gnt_valid;
  logic [1:0]  w_gnt;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic [2:0]  w_grant_oh;
  logic        w_done;
  logic        w_drop;

  // A master in its ack cycle still shows req high; it must not be re-granted.
  assign w_req = {m2_req_i & ~r_ack[2], m1_req_i & ~r_ack[1], m0_req_i & ~r_ack[0]};
  assign w_gnt_valid = |w_req;

  always_comb begin
    w_gnt   = 2'd0;
    w_addr  = m0_addr_i;
    w_wdata = m0_wdata_i;
    w_we    = m0_we_i;
    if (w_req[0]) begin
      w_gnt = 2'd0;
    end else if (w_req[1] && !(w_req[2] && r_last_ex)) begin
      w_gnt = 2'd1;
    end else if (w_req[2]) begin
      w_gnt = 2'd2;
    end
    case (w_gnt)
      2'd1: begin
        w_addr  = m1_addr_i;
        w_wdata = m1_wdata_i;
        w_we    = m1_we_i;
      end
      2'd2: begin
        w_addr  = m2_addr_i;
        w_wdata = m2_wdata_i;
        w_we    = m2_we_i;
      end
      default: ;
    endcase
  end

  assign w_grant_oh = 3'b001 << r_grant;
  assign w_done     = (r_state == BUSY) && (s_ack_i || (r_cnt == LP_CNT_LAST));
  // A flush arriving in the completion cycle itself also kills the fetch response.
  assign w_drop     = (r_grant == 2'd2) && (r_discard || flush_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= 2'd0;
      r_discard <= 1'b0;
      r_last_ex <= 1'b0;
      r_cnt     <= 8'd0;
      r_ack     <= 3'b000;
      r_err     <= 3'b000;
      r_rdata   <= 32'd0;
      s_addr_o  <= 32'd0;
      s_wdata_o <= 32'd0;
      s_we_o    <= 1'b0;
    end else begin
      r_ack <= 3'b000;
      r_err <= 3'b000;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant   <= w_gnt;
            s_addr_o  <= w_addr;
            s_wdata_o <= w_wdata;
            s_we_o    <= w_we;
            r_cnt     <= 8'd0;
            r_discard <= 1'b0;
            if (w_gnt == 2'd1) r_last_ex <= 1'b1;
            if (w_gnt == 2'd2) r_last_ex <= 1'b0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i && (r_grant == 2'd2)) r_discard <= 1'b1;
          if (w_done) begin
            r_state <= IDLE;
            r_rdata <= (s_ack_i && !s_we_o) ? s_rdata_i : 32'd0;
            if (!w_drop) begin
              r_ack <= w_grant_oh;
              r_err <= s_ack_i ? 3'b000 : w_grant_oh;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_req_o    = (r_state == BUSY);
  assign m0_ack_o   = r_ack[0];
  assign m1_ack_o   = r_ack[1];
  assign m2_ack_o   = r_ack[2];
  assign m0_err_o   = r_err[0];
  assign m1_err_o   = r_err[1];
  assign m2_err_o   = r_err[2];
  assign m0_rdata_o = r_ack[0] ? r_rdata : 32'd0;
  assign m1_rdata_o = r_ack[1] ? r_rdata : 32'd0;
  assign m2_rdata_o = r_ack[2] ? r_rdata : 32'd0;
  assign hold_ex_o  = m1_req_i & ~m1_ack_o;
  assign hold_if_o  = m2_req_i & ~m2_ack_o;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
// Masters and slave are modelled per cycle; expected acks are queued and compared against observed acks.
module tb_bus_arbiter;
  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} req_t;
  typedef struct packed {logic [1:0] m; logic [31:0] d; logic e; logic [15:0] c;} ev_t;

  logic clk, rst;
  logic m0_req_i, m0_we_i, m0_ack_o, m0_err_o;
  logic m1_req_i, m1_we_i, m1_ack_o, m1_err_o;
  logic m2_req_i, m2_we_i, m2_ack_o, m2_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [31:0] m2_addr_i, m2_wdata_i, m2_rdata_o;
  logic s_req_o, s_we_o, s_ack_i, flush_i, hold_ex_o, hold_if_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;

  req_t pq [3][$];
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [31:0] mem [logic [31:0]];
  int total, bad, cyc, flush_cyc, slave_lat, wcnt;
  bit flush_drop, late_ack;
  bit [2:0] got_ack;
  logic [255:0] sreq_tr, hex_tr, hif_tr;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m2_req_i(m2_req_i), .m2_addr_i(m2_addr_i), .m2_we_i(m2_we_i), .m2_wdata_i(m2_wdata_i),
    .m2_rdata_o(m2_rdata_o), .m2_ack_o(m2_ack_o), .m2_err_o(m2_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_we_o(s_we_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .flush_i(flush_i),
    .hold_ex_o(hold_ex_o), .hold_if_o(hold_if_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // One clock cycle: drive masters after the edge, then run slave and ack monitor at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    flush_i = 1'b0;
    if (cyc == flush_cyc) begin
      flush_i = 1'b1;
      if (flush_drop) pq[2].delete();
    end
    for (int n = 0; n < 3; n++) begin
      if (got_ack[n]) begin
        if (pq[n].size() > 0) void'(pq[n].pop_front());
        got_ack[n] = 1'b0;
      end
    end
    m0_req_i = (pq[0].size() > 0);
    if (pq[0].size() > 0) begin m0_addr_i = pq[0][0].addr; m0_we_i = pq[0][0].we; m0_wdata_i = pq[0][0].wdata; end
    m1_req_i = (pq[1].size() > 0);
    if (pq[1].size() > 0) begin m1_addr_i = pq[1][0].addr; m1_we_i = pq[1][0].we; m1_wdata_i = pq[1][0].wdata; end
    m2_req_i = (pq[2].size() > 0);
    if (pq[2].size() > 0) begin m2_addr_i = pq[2][0].addr; m2_we_i = pq[2][0].we; m2_wdata_i = pq[2][0].wdata; end
    @(negedge clk);
    if (cyc >= 0 && cyc < 256) begin
      sreq_tr[cyc] = s_req_o;
      hex_tr[cyc]  = hold_ex_o;
      hif_tr[cyc]  = hold_if_o;
    end
    s_ack_i = 1'b0;
    if (late_ack) begin
      s_ack_i = 1'b1;
      s_rdata_i = 32'hBAD0_BAD0;
    end else if (s_req_o) begin
      if (slave_lat >= 0 && wcnt == slave_lat) begin
        s_ack_i = 1'b1;
        wcnt = 0;
        if (s_we_o) begin
          mem[s_addr_o] = s_wdata_o;
          s_rdata_i = 32'hFFFF_FFFF;
        end else begin
          s_rdata_i = mem.exists(s_addr_o) ? mem[s_addr_o] : dflt(s_addr_o);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    if (m0_ack_o || m0_err_o) begin obs_q.push_back({2'd0, m0_rdata_o, m0_err_o, 16'(cyc)}); got_ack[0] = 1'b1; end
    if (m1_ack_o || m1_err_o) begin obs_q.push_back({2'd1, m1_rdata_o, m1_err_o, 16'(cyc)}); got_ack[1] = 1'b1; end
    if (m2_ack_o || m2_err_o) begin obs_q.push_back({2'd2, m2_rdata_o, m2_err_o, 16'(cyc)}); got_ack[2] = 1'b1; end
  endtask

  task automatic do_reset();
    for (int n = 0; n < 3; n++) pq[n].delete();
    got_ack = 3'b000;
    flush_cyc = -1;
    flush_drop = 1'b0;
    late_ack = 1'b0;
    wcnt = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    sreq_tr = '0;
    hex_tr = '0;
    hif_tr = '0;
    cyc = -1;
  endtask

  task automatic test_reset();
    do_reset();
    slave_lat = -1;
    pq[0].push_back('{addr: 32'h0000_0040, we: 1'b1, wdata: 32'hCAFE_0001});
    step();
    step();
    total++;
    if ({s_req_o, s_we_o, s_addr_o, s_wdata_o} !== {1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_0001}) begin
      bad++; $display("FAIL rst_busy_fields: got req=%0d we=%0d addr=%h wdata=%h, expected 1 1 00000040 cafe0001", s_req_o, s_we_o, s_addr_o, s_wdata_o);
    end
    rst = 1'b1;
    pq[0].delete();
    step();
    total++;
    if ({s_req_o, s_we_o, s_addr_o, s_wdata_o} !== 66'd0) begin
      bad++; $display("FAIL rst_slave_side: got req=%0d we=%0d addr=%h wdata=%h, expected all 0", s_req_o, s_we_o, s_addr_o, s_wdata_o);
    end
    total++;
    if ({m0_ack_o, m1_ack_o, m2_ack_o, m0_err_o, m1_err_o, m2_err_o, m0_rdata_o, m1_rdata_o, m2_rdata_o} !== 102'd0) begin
      bad++; $display("FAIL rst_master_side: got acks=%b errs=%b, expected 000 000 and zero rdata", {m0_ack_o, m1_ack_o, m2_ack_o}, {m0_err_o, m1_err_o, m2_err_o});
    end
    rst = 1'b0;
    late_ack = 1'b1;
    step();
    step();
    late_ack = 1'b0;
    step();
    step();
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL rst_late_ack: got %0d master acks, expected 0", obs_q.size());
    end
    total++;
    if (sreq_tr[6:3] !== 4'b0000) begin
      bad++; $display("FAIL rst_stays_idle: got s_req trace %b, expected 0000", sreq_tr[6:3]);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    slave_lat = 0;
    mem[32'h0000_1000] = 32'hDEAD_BEEF;
    pq[1].push_back('{addr: 32'h0000_1000, we: 1'b0, wdata: 32'd0});
    exp_q.push_back({2'd1, 32'hDEAD_BEEF, 1'b0, 16'd2});
    repeat (5) step();
    total++;
    if (sreq_tr[4:0] !== 5'b00010) begin
      bad++; $display("FAIL single_sreq: got trace %b, expected 00010", sreq_tr[4:0]);
    end
    total++;
    if (hex_tr[4:0] !== 5'b00011) begin
      bad++; $display("FAIL single_hold_ex: got trace %b, expected 00011", hex_tr[4:0]);
    end
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL single_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL single_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL single_extra: got %0d extra acks, expected 0", obs_q.size());
    end
  endtask

  task automatic test_priority();
    do_reset();
    slave_lat = 0;
    pq[0].push_back('{addr: 32'h0000_2000, we: 1'b1, wdata: 32'h1234_5678});
    pq[1].push_back('{addr: 32'h0000_2000, we: 1'b0, wdata: 32'd0});
    pq[2].push_back('{addr: 32'h0000_3000, we: 1'b0, wdata: 32'd0});
    exp_q.push_back({2'd0, 32'd0, 1'b0, 16'd2});
    exp_q.push_back({2'd1, 32'h1234_5678, 1'b0, 16'd4});
    exp_q.push_back({2'd2, dflt(32'h0000_3000), 1'b0, 16'd6});
    repeat (8) step();
    total++;
    if (hif_tr[7:0] !== 8'b00111111) begin
      bad++; $display("FAIL prio_hold_if: got trace %b, expected 00111111", hif_tr[7:0]);
    end
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL prio_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL prio_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL prio_extra: got %0d extra acks, expected 0", obs_q.size());
    end
  endtask

  task automatic test_alternate();
    // Phase A: m1/m2 both busy with a one-wait slave; a flush during an m1 access must not matter.
    do_reset();
    slave_lat = 1;
    flush_cyc = 1;
    for (int i = 0; i < 3; i++) begin
      pq[1].push_back('{addr: 32'h0000_0100 + 32'(4 * i), we: 1'b0, wdata: 32'd0});
      pq[2].push_back('{addr: 32'h0000_0200 + 32'(4 * i), we: 1'b0, wdata: 32'd0});
      exp_q.push_back({2'd1, dflt(32'h0000_0100 + 32'(4 * i)), 1'b0, 16'(3 + 6 * i)});
      exp_q.push_back({2'd2, dflt(32'h0000_0200 + 32'(4 * i)), 1'b0, 16'(6 + 6 * i)});
    end
    repeat (21) step();
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL alt_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL alt_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL alt_extra: got %0d extra acks, expected 0", obs_q.size());
    end
    // Phase B: m0 steals the slot after an m1 grant; m2 must still beat m1 next.
    do_reset();
    slave_lat = 0;
    pq[1].push_back('{addr: 32'h0000_0110, we: 1'b0, wdata: 32'd0});
    pq[1].push_back('{addr: 32'h0000_0114, we: 1'b0, wdata: 32'd0});
    step();
    pq[0].push_back('{addr: 32'h0000_0050, we: 1'b0, wdata: 32'd0});
    pq[2].push_back('{addr: 32'h0000_0210, we: 1'b0, wdata: 32'd0});
    exp_q.push_back({2'd1, dflt(32'h0000_0110), 1'b0, 16'd2});
    exp_q.push_back({2'd0, dflt(32'h0000_0050), 1'b0, 16'd4});
    exp_q.push_back({2'd2, dflt(32'h0000_0210), 1'b0, 16'd6});
    exp_q.push_back({2'd1, dflt(32'h0000_0114), 1'b0, 16'd8});
    repeat (10) step();
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL last_ex_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL last_ex_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL last_ex_extra: got %0d extra acks, expected 0", obs_q.size());
    end
  endtask

  task automatic test_flush();
    do_reset();
    slave_lat = 3;
    flush_cyc = 2;
    flush_drop = 1'b1;
    pq[2].push_back('{addr: 32'h0000_0300, we: 1'b0, wdata: 32'd0});
    repeat (7) step();
    total++;
    if (sreq_tr[6:0] !== 7'b0011110) begin
      bad++; $display("FAIL flush_sreq: got trace %b, expected 0011110", sreq_tr[6:0]);
    end
    flush_cyc = -1;
    slave_lat = 0;
    pq[2].push_back('{addr: 32'h0000_0304, we: 1'b0, wdata: 32'd0});
    exp_q.push_back({2'd2, dflt(32'h0000_0304), 1'b0, 16'd9});
    repeat (4) step();
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL flush_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL flush_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL flush_extra: got %0d extra acks, expected 0", obs_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    slave_lat = -1;
    pq[1].push_back('{addr: 32'h0000_0500, we: 1'b0, wdata: 32'd0});
    exp_q.push_back({2'd1, 32'd0, 1'b1, 16'd5});
    repeat (6) step();
    late_ack = 1'b1;
    step();
    late_ack = 1'b0;
    repeat (3) step();
    total++;
    if (sreq_tr[9:0] !== 10'b0000011110) begin
      bad++; $display("FAIL timeout_sreq: got trace %b, expected 0000011110", sreq_tr[9:0]);
    end
    total++;
    if (hex_tr[6:0] !== 7'b0011111) begin
      bad++; $display("FAIL timeout_hold_ex: got trace %b, expected 0011111", hex_tr[6:0]);
    end
    while (exp_q.size() > 0) begin
      ev_t ex, ob;
      ex = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL timeout_ack: got none, expected m%0d d=%h err=%0d cyc=%0d", ex.m, ex.d, ex.e, ex.c);
      end else begin
        ob = obs_q.pop_front();
        if (ob !== ex) begin
          bad++; $display("FAIL timeout_ack: got m%0d d=%h err=%0d cyc=%0d, expected m%0d d=%h err=%0d cyc=%0d", ob.m, ob.d, ob.e, ob.c, ex.m, ex.d, ex.e, ex.c);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++; $display("FAIL timeout_extra: got %0d extra acks, expected 0", obs_q.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    flush_cyc = -1;
    slave_lat = 0;
    wcnt = 0;
    flush_drop = 1'b0;
    late_ack = 1'b0;
    got_ack = 3'b000;
    rst = 1'b1;
    flush_i = 1'b0;
    s_ack_i = 1'b0;
    s_rdata_i = 32'd0;
    m0_req_i = 1'b0; m0_addr_i = 32'd0; m0_we_i = 1'b0; m0_wdata_i = 32'd0;
    m1_req_i = 1'b0; m1_addr_i = 32'd0; m1_we_i = 1'b0; m1_wdata_i = 32'd0;
    m2_req_i = 1'b0; m2_addr_i = 32'd0; m2_we_i = 1'b0; m2_wdata_i = 32'd0;
    test_reset();
    test_single_read();
    test_priority();
    test_alternate();
    test_flush();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
